// File: rtl/input_buffer_sc.sv
// input_buffer_sc: multi-channel snapshot buffer.
// On a start pulse, captures LENGTH consecutive samples from each of NSINK channels into per-channel
// RAM banks. It then replays them as one packet per channel: channel 0 first, with sop/eop framing.
// Optional feature macro: INPUT_BUFFER_BUSY_EN adds a registered 'busy' output.
module input_buffer_sc #(
  parameter int unsigned NSINK  = 3,
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned LENGTH = 2048
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sink_start,
  input  logic [WIDTH-1:0] sink_data [0:NSINK-1],
`ifdef INPUT_BUFFER_BUSY_EN
  output logic             busy,
`endif
  output logic             source_valid,
  output logic             source_sop,
  output logic             source_eop,
  output logic [WIDTH-1:0] source_data
);

  localparam int unsigned IdxW  = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int unsigned AddrW = ((NSINK * LENGTH) > 1) ? $clog2(NSINK * LENGTH) : 1;
  localparam int unsigned ChW   = (NSINK > 1) ? $clog2(NSINK) : 1;

  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(LENGTH - 1);
  localparam logic [AddrW-1:0] AddrLast = AddrW'(NSINK * LENGTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StReplay
  } state_e;

  state_e            state_q;
  logic [IdxW-1:0]   widx_q;      // capture sample index
  logic [AddrW-1:0]  raddr_q;     // replay word address, ch*LENGTH + index
  logic [ChW-1:0]    rd_ch_q;     // channel of the word at raddr_q
  logic              rd_done_q;   // all reads issued for this snapshot
  // Read stage: RAM data plus framing for the word just read.
  logic              rd_vld_q;
  logic              rd_sop_q;
  logic              rd_eop_q;
  logic              rd_last_q;
  logic [ChW-1:0]    sel_q;
  // Set while the output register holds the final word of the snapshot.
  logic              out_last_q;
`ifdef INPUT_BUFFER_BUSY_EN
  logic              busy_q;
`endif

  logic              wr_en;
  logic              rd_en;
  logic [IdxW-1:0]   ridx;
  logic [WIDTH-1:0]  bank_rd [NSINK];
  logic [WIDTH-1:0]  rd_mux;

  // widx_q is zero whenever the FSM is idle, so the start edge writes sample 0.
  assign wr_en = ((state_q == StIdle) && sink_start) || (state_q == StCapture);
  assign rd_en = (state_q == StReplay) && !rd_done_q;
  // LENGTH is a power of two, so the low address bits are the sample index.
  assign ridx  = raddr_q[IdxW-1:0];

  // One RAM bank per channel: all channels written in parallel, one bank read per cycle.
  for (genvar c = 0; c < NSINK; c++) begin : g_bank
    logic [WIDTH-1:0] mem_q [LENGTH];
    logic [WIDTH-1:0] rd_q;

    // Synchronous write of this channel's sample and synchronous read for replay.
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem_q[widx_q] <= sink_data[c];
      end
      if (rd_en) begin
        rd_q <= mem_q[ridx];
      end
    end

    assign bank_rd[c] = rd_q;
  end

  // Select the bank read on the previous cycle.
  always_comb begin
    rd_mux = '0;
    for (int unsigned c = 0; c < NSINK; c++) begin
      if (sel_q == ChW'(c)) begin
        rd_mux = bank_rd[c];
      end
    end
  end

  // Control FSM with registered read pipeline and registered stream outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      widx_q       <= '0;
      raddr_q      <= '0;
      rd_ch_q      <= '0;
      rd_done_q    <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_sop_q     <= 1'b0;
      rd_eop_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      sel_q        <= '0;
      out_last_q   <= 1'b0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_data  <= '0;
`ifdef INPUT_BUFFER_BUSY_EN
      busy_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sink_start) begin
            state_q <= StCapture;
            widx_q  <= widx_q + 1'b1;
`ifdef INPUT_BUFFER_BUSY_EN
            busy_q  <= 1'b1;
`endif
          end
        end

        StCapture: begin
          // Index wraps back to zero on the last sample, ready for the next snapshot.
          widx_q <= widx_q + 1'b1;
          if (widx_q == IdxLast) begin
            state_q   <= StReplay;
            raddr_q   <= '0;
            rd_ch_q   <= '0;
            rd_done_q <= 1'b0;
          end
        end

        StReplay: begin
          // Read stage.
          rd_vld_q <= rd_en;
          if (rd_en) begin
            rd_sop_q  <= (ridx == '0);
            rd_eop_q  <= (ridx == IdxLast);
            rd_last_q <= (raddr_q == AddrLast);
            sel_q     <= rd_ch_q;
            if (raddr_q == AddrLast) begin
              rd_done_q <= 1'b1;
            end else begin
              raddr_q <= raddr_q + 1'b1;
            end
            if (ridx == IdxLast) begin
              rd_ch_q <= rd_ch_q + 1'b1;
            end
          end

          // Output stage; data holds while no word is presented.
          source_valid <= rd_vld_q;
          source_sop   <= rd_vld_q && rd_sop_q;
          source_eop   <= rd_vld_q && rd_eop_q;
          if (rd_vld_q) begin
            source_data <= rd_mux;
          end
          out_last_q <= rd_vld_q && rd_last_q;

          // Leave once the final word has been presented for its one cycle.
          if (source_valid && out_last_q) begin
            state_q <= StIdle;
`ifdef INPUT_BUFFER_BUSY_EN
            busy_q  <= 1'b0;
`endif
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef INPUT_BUFFER_BUSY_EN
  assign busy = busy_q;
`endif

endmodule

// File: tb/tb_input_buffer_sc.sv
// Testbench for input_buffer_sc (NSINK=3, WIDTH=14, LENGTH=8).
// The expected stream is derived from captured samples: word k = channel k/LENGTH, sample k%LENGTH.
module tb_input_buffer_sc;

  localparam int unsigned NS = 3;
  localparam int unsigned W  = 14;
  localparam int unsigned L  = 8;
  localparam int unsigned NL = NS * L;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         sink_start;
  logic [W-1:0] sink_data [0:NS-1];
  logic         source_valid;
  logic         source_sop;
  logic         source_eop;
  logic [W-1:0] source_data;
`ifdef INPUT_BUFFER_BUSY_EN
  logic         busy;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  input_buffer_sc #(
    .NSINK (NS),
    .WIDTH (W),
    .LENGTH(L)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sink_start  (sink_start),
    .sink_data   (sink_data),
`ifdef INPUT_BUFFER_BUSY_EN
    .busy        (busy),
`endif
    .source_valid(source_valid),
    .source_sop  (source_sop),
    .source_eop  (source_eop),
    .source_data (source_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_busy(input string tag, input logic exp);
`ifdef INPUT_BUFFER_BUSY_EN
    chk(tag, 32'(busy), 32'(exp));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(source_valid), 32'd0);
    chk({tag, "_sop"}, 32'(source_sop), 32'd0);
    chk({tag, "_eop"}, 32'(source_eop), 32'd0);
  endtask

  task automatic rand_data();
    for (int c = 0; c < NS; c++) sink_data[c] = W'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    sink_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      rand_data();
      tick();
      chk_idle("idle");
      chk_busy("idle_busy", 1'b0);
    end
  endtask

  // mode: 0 = 0x100*(ch+1)+i pattern, 1 = random, 2 = negative samples.
  // extra: 0 = single start pulse, 1 = extra pulses in capture and replay, 2 = start held high.
  // abort_t: replay cycle at which reset is asserted (0 = none).
  task automatic run_snapshot(input int mode, input int extra, input int abort_t);
    logic [W-1:0] cap [NS][L];
    logic [W-1:0] v;
    int k;
    for (int i = 0; i < L; i++) begin
      for (int c = 0; c < NS; c++) begin
        case (mode)
          0:       v = W'(32'h100 * (c + 1) + i);
          2:       v = (i == 0) ? 14'h3800 : {1'b1, 13'($urandom)};
          default: v = W'($urandom);
        endcase
        sink_data[c] = v;
        cap[c][i]    = v;
      end
      sink_start = (i == 0) || (extra == 1 && i == 3) || (extra == 2);
      tick();
      chk_idle("capture");
      chk_busy("capture_busy", 1'b1);
    end
    for (int t = L; t <= L + NL + 1; t++) begin
      rand_data();
      sink_start = (extra == 1 && (t == L + 5 || t == L + NL + 1)) || (extra == 2);
      tick();
      if (t == abort_t) begin
        sink_start = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk_idle("abort");
        chk("abort_data", 32'(source_data), 32'd0);
        chk_busy("abort_busy", 1'b0);
        tick();
        tick();
        chk_idle("abort_hold");
        reset_n = 1'b1;
        return;
      end
      if (t >= L + 1 && t <= L + NL) begin
        k = t - L - 1;
        chk("valid", 32'(source_valid), 32'd1);
        chk("data", 32'(source_data), 32'(cap[k / L][k % L]));
        chk("sop", 32'(source_sop), 32'((k % L) == 0));
        chk("eop", 32'(source_eop), 32'((k % L) == L - 1));
      end else begin
        chk_idle("replay_gap");
      end
      chk_busy("replay_busy", 1'(t <= L + NL));
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    sink_start = 1'b0;
    for (int c = 0; c < NS; c++) sink_data[c] = '0;

    // Reset held with start toggling.
    for (int i = 0; i < 5; i++) begin
      sink_start = ~sink_start;
      rand_data();
      tick();
      chk_idle("reset");
      chk("reset_data", 32'(source_data), 32'd0);
      chk_busy("reset_busy", 1'b0);
    end
    reset_n = 1'b1;
    idle_cycles(4);

    // Directed pattern.
    run_snapshot(0, 0, 0);
    idle_cycles(3);
    // Starts during capture and replay are ignored.
    run_snapshot(1, 1, 0);
    idle_cycles(3);
    // Negative samples.
    run_snapshot(2, 0, 0);
    idle_cycles(2);
    // Start held high: back-to-back snapshots at the minimum period.
    run_snapshot(1, 2, 0);
    run_snapshot(0, 2, 0);
    idle_cycles(3);
    // Reset mid-replay, then a full snapshot.
    run_snapshot(1, 0, L + 10);
    idle_cycles(4);
    run_snapshot(1, 0, 0);
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
